ace_snoop_responder: RTL
========================

ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

Interface
REQ-001 SHALL have parameter LineBeats, default 4, CD beats per cache line (power of two, >=2).
REQ-002 SHALL have parameters snoop_req_t and snoop_resp_t, default logic, giving the AC/CR/CD struct types from ace_pkg.
REQ-003 SHALL have parameters addr_t and data_t, default logic, giving the line address and CD beat data types.
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_i  in  1  reset; synchronous and active-high.
REQ-006 snoop_req_i  in  snoop_req_t  ac, ac_valid, cr_ready, cd_ready from the CCU.
REQ-007 snoop_resp_o  out  snoop_resp_t  ac_ready, cr_valid, cr_resp, cd_valid, cd.
REQ-008 lkp_valid_o  out  1  tag lookup request; lkp_addr_o  out  addr_t  line address; lkp_ready_i  in  1  lookup accepted.
REQ-009 lkp_rsp_valid_i  in  1  result valid; lkp_hit_i, lkp_dirty_i, lkp_unique_i  in  1 each  line state.
REQ-010 rd_valid_i  in  1  cache data beat valid; rd_data_i  in  data_t  beat; rd_ready_o  out  1  beat consumed.
REQ-011 upd_valid_o  out  1  state update; upd_inval_o  out  1  1=Invalid, 0=SharedClean; upd_ready_i  in  1.

Function
REQ-012 FSM states SHALL be IDLE, LOOKUP, WAIT_RSP, RESP, DATA, UPDATE.
REQ-013 ac_ready SHALL be 1 only in IDLE; an AC handshake SHALL latch ac.addr and ac.snoop and move to LOOKUP.
REQ-014 LOOKUP SHALL drive lkp_valid_o=1 with the latched address until lkp_ready_i, then move to WAIT_RSP.
REQ-015 WAIT_RSP SHALL latch hit/dirty/unique on lkp_rsp_valid_i and move to RESP.
REQ-016 Miss, or a snoop not listed below, SHALL yield cr_resp all zero, no CD, no update.
REQ-017 ReadOnce hit: DataTransfer=1, IsShared=1, PassDirty=0, WasUnique=unique; no update.
REQ-018 ReadShared/ReadClean/ReadNotSharedDirty hit: DataTransfer=1, IsShared=1, PassDirty=dirty, WasUnique=unique; update to SharedClean.
REQ-019 ReadUnique hit: DataTransfer=1, PassDirty=dirty, WasUnique=unique; update to Invalid.
REQ-020 CleanInvalid hit: DataTransfer=dirty, PassDirty=dirty; update to Invalid.
REQ-021 CleanShared hit: DataTransfer=dirty, PassDirty=dirty, IsShared=1; update to SharedClean only if dirty.
REQ-022 MakeInvalid hit: cr_resp zero, no CD; update to Invalid.
REQ-023 Error SHALL always be 0.
REQ-024 RESP SHALL hold cr_valid=1 with stable cr_resp until cr_ready; then DATA if DataTransfer, else UPDATE if an update is due, else IDLE.
REQ-025 DATA SHALL forward cd_valid=rd_valid_i, cd.data=rd_data_i, rd_ready_o=cd_ready; cd.last=1 on beat LineBeats-1.
REQ-026 Beat counter SHALL be log2(LineBeats) bits, clear on entering DATA, and increment per CD handshake; wrap on the last beat.
REQ-027 After last-beat handshake: UPDATE if due, else IDLE.
REQ-028 UPDATE SHALL hold upd_valid_o=1 until upd_ready_i, then return to IDLE.
REQ-029 A new AC SHALL never be accepted before the current transaction returns to IDLE (one outstanding snoop).
REQ-030 All outputs not named active in a state SHALL be 0.

Reset
REQ-031 While rst_i=1 at a clock edge: state IDLE; counter, latched AC and lookup results 0.
REQ-032 Reset mid-transaction SHALL drop it; the cycle after reset releases, ac_ready=1 and all other outputs 0.

Structure
REQ-033 The state enum and a crresp-build function SHALL live in ccu_ctrl_pkg; acsnoop_t/crresp_t come from ace_pkg.
REQ-034 No sub-module; single FSM plus counter.

Verification
REQ-035 ReadShared, hit dirty unique -> CR {DataTransfer=1, PassDirty=1, IsShared=1, WasUnique=1}; 4 CD beats, last on 4th; update Invalid=0.
REQ-036 ReadUnique miss -> CR all zero; no cd_valid, no upd_valid_o; IDLE after cr handshake.
REQ-037 ReadOnce hit clean, cd_ready toggling 1/0 -> data beats held stable while stalled; 4 beats in order, no update.
REQ-038 CleanInvalid hit clean -> CR zero; upd_valid_o with upd_inval_o=1; ac_valid held high meanwhile -> ac_ready stays 0.
REQ-039 rst_i asserted during DATA beat 2 -> next cycle all outputs 0 except ac_ready=1; following ReadShared completes normally.
REQ-040 MakeInvalid hit with upd_ready_i low 5 cycles -> upd_valid_o held 5 cycles, IDLE after handshake.

Source files
------------

// File: rtl/ace_pkg.sv
// ACE snoop-channel types shared by the coherency controller blocks:
// AC request, CR response and CD data channel encodings.
package ace_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;

  typedef enum logic [3:0] {
    SNP_READ_ONCE             = 4'b0000,
    SNP_READ_SHARED           = 4'b0001,
    SNP_READ_CLEAN            = 4'b0010,
    SNP_READ_NOT_SHARED_DIRTY = 4'b0011,
    SNP_READ_UNIQUE           = 4'b0111,
    SNP_CLEAN_SHARED          = 4'b1000,
    SNP_CLEAN_INVALID         = 4'b1001,
    SNP_MAKE_INVALID          = 4'b1101,
    SNP_DVM_COMPLETE          = 4'b1110,
    SNP_DVM_MESSAGE           = 4'b1111
  } acsnoop_t;

  // Field order matches CRRESP[4:0].
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    addr_t    addr;
    acsnoop_t snoop;
  } ac_chan_t;

  typedef struct packed {
    data_t data;
    logic  last;
  } cd_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

endpackage

// File: rtl/ccu_ctrl_pkg.sv
// Snoop responder control: FSM state encoding and the snoop/line-state
// decode into the CR response and the follow-up line-state update.
package ccu_ctrl_pkg;

  import ace_pkg::*;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_RSP,
    RESP,
    DATA,
    UPDATE
  } state_t;

  typedef struct packed {
    logic due;
    logic inval;
  } upd_action_t;

  function automatic crresp_t build_crresp(acsnoop_t snoop, logic hit,
                                           logic dirty, logic is_unique);
    crresp_t r;
    r = '0;
    if (hit) begin
      case (snoop)
        SNP_READ_ONCE: begin
          r.data_transfer = 1'b1;
          r.is_shared     = 1'b1;
          r.was_unique    = is_unique;
        end
        SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY: begin
          r.data_transfer = 1'b1;
          r.is_shared     = 1'b1;
          r.pass_dirty    = dirty;
          r.was_unique    = is_unique;
        end
        SNP_READ_UNIQUE: begin
          r.data_transfer = 1'b1;
          r.pass_dirty    = dirty;
          r.was_unique    = is_unique;
        end
        SNP_CLEAN_INVALID: begin
          r.data_transfer = dirty;
          r.pass_dirty    = dirty;
        end
        SNP_CLEAN_SHARED: begin
          r.data_transfer = dirty;
          r.pass_dirty    = dirty;
          r.is_shared     = 1'b1;
        end
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic upd_action_t build_update(acsnoop_t snoop, logic hit,
                                               logic dirty);
    upd_action_t u;
    u = '0;
    if (hit) begin
      case (snoop)
        SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY:
          u = '{due: 1'b1, inval: 1'b0};
        SNP_READ_UNIQUE, SNP_CLEAN_INVALID, SNP_MAKE_INVALID:
          u = '{due: 1'b1, inval: 1'b1};
        SNP_CLEAN_SHARED:
          u = '{due: dirty, inval: 1'b0};
        default: u = '0;
      endcase
    end
    return u;
  endfunction

endpackage

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: one outstanding snoop at a time, walking
// tag lookup -> CR response -> optional CD line transfer -> state update.
module ace_snoop_responder
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned LineBeats    = 4,
  parameter type         snoop_req_t  = ace_pkg::snoop_req_t,
  parameter type         snoop_resp_t = ace_pkg::snoop_resp_t,
  parameter type         addr_t       = ace_pkg::addr_t,
  parameter type         data_t       = ace_pkg::data_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  snoop_req_t  snoop_req_i,
  output snoop_resp_t snoop_resp_o,
  output logic        lkp_valid_o,
  output addr_t       lkp_addr_o,
  input  logic        lkp_ready_i,
  input  logic        lkp_rsp_valid_i,
  input  logic        lkp_hit_i,
  input  logic        lkp_dirty_i,
  input  logic        lkp_unique_i,
  input  logic        rd_valid_i,
  input  data_t       rd_data_i,
  output logic        rd_ready_o,
  output logic        upd_valid_o,
  output logic        upd_inval_o,
  input  logic        upd_ready_i
);

  localparam int unsigned CntWidth = $clog2(LineBeats);
  typedef logic [CntWidth-1:0] beat_t;
  localparam beat_t LastBeat = beat_t'(LineBeats - 1);

  state_t            state, state_next;
  beat_t             beat;
  addr_t             ac_addr;
  ace_pkg::acsnoop_t ac_snoop;
  logic              hit, dirty, is_unique;

  ace_pkg::crresp_t  cr_resp;
  upd_action_t       upd;
  logic              ac_hs, rsp_take, cr_hs, cd_hs;

  assign cr_resp  = build_crresp(ac_snoop, hit, dirty, is_unique);
  assign upd      = build_update(ac_snoop, hit, dirty);
  assign ac_hs    = (state == IDLE) && snoop_req_i.ac_valid;
  assign rsp_take = (state == WAIT_RSP) && lkp_rsp_valid_i;
  assign cr_hs    = (state == RESP) && snoop_req_i.cr_ready;
  assign cd_hs    = (state == DATA) && rd_valid_i && snoop_req_i.cd_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat      <= '0;
      ac_addr   <= '0;
      ac_snoop  <= ace_pkg::acsnoop_t'('0);
      hit       <= 1'b0;
      dirty     <= 1'b0;
      is_unique <= 1'b0;
    end else begin
      if (ac_hs) begin
        ac_addr  <= snoop_req_i.ac.addr;
        ac_snoop <= snoop_req_i.ac.snoop;
      end
      if (rsp_take) begin
        hit       <= lkp_hit_i;
        dirty     <= lkp_dirty_i;
        is_unique <= lkp_unique_i;
      end
      // The counter wraps to zero on the last beat since LineBeats is 2^n.
      if (cr_hs && cr_resp.data_transfer) beat <= '0;
      else if (cd_hs)                     beat <= beat + beat_t'(1);
    end
  end

  // NOTE: every signal written here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    snoop_resp_o = '0;
    lkp_valid_o  = 1'b0;
    lkp_addr_o   = '0;
    rd_ready_o   = 1'b0;
    upd_valid_o  = 1'b0;
    upd_inval_o  = 1'b0;

    unique case (state)
      IDLE: begin
        snoop_resp_o.ac_ready = 1'b1;
        if (snoop_req_i.ac_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        lkp_valid_o = 1'b1;
        lkp_addr_o  = ac_addr;
        if (lkp_ready_i) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (lkp_rsp_valid_i) state_next = RESP;
      end
      RESP: begin
        snoop_resp_o.cr_valid = 1'b1;
        snoop_resp_o.cr_resp  = cr_resp;
        if (snoop_req_i.cr_ready) begin
          if (cr_resp.data_transfer) state_next = DATA;
          else if (upd.due)          state_next = UPDATE;
          else                       state_next = IDLE;
        end
      end
      DATA: begin
        snoop_resp_o.cd_valid   = rd_valid_i;
        snoop_resp_o.cd.data    = rd_data_i;
        snoop_resp_o.cd.last    = (beat == LastBeat);
        rd_ready_o              = snoop_req_i.cd_ready;
        if (cd_hs && (beat == LastBeat)) state_next = upd.due ? UPDATE : IDLE;
      end
      UPDATE: begin
        upd_valid_o = 1'b1;
        upd_inval_o = upd.inval;
        if (upd_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
